// File: rtl/vec_sdram_writer.sv
// vec_sdram_writer: write-back engine that streams one N-element int8 result
// vector to the SDRAM write port as a burst of SDRAM_W-bit beats.
// Beat k carries data_in[k*SDRAM_W +: SDRAM_W], element 0 in the low byte of
// beat 0, and beat k goes to start_addr + k*SDRAM_W/8 (32-bit wrap).
// Optional feature macro: VEC_SDRAM_WR_BYTE_EN adds a per-byte write enable
// output, wr_be, which masks the zero padding of a partial last beat.
module vec_sdram_writer #(
  parameter int N       = 176,
  parameter int SDRAM_W = 128,
  parameter int DATA_W  = N * 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [31:0]           start_addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_valid,
  output logic [31:0]           wr_addr,
  output logic [SDRAM_W-1:0]    wr_data,
  output logic                  wr_last,
  input  logic                  wr_ready
`ifdef VEC_SDRAM_WR_BYTE_EN
  ,
  output logic [SDRAM_W/8-1:0]  wr_be
`endif
);

  // Derived geometry; BEATS is not meant to be overridden.
  localparam int BEATS    = (DATA_W + SDRAM_W - 1) / SDRAM_W;
  localparam int PAD_W    = BEATS * SDRAM_W;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BYTES    = SDRAM_W / 8;
  localparam int REM_BITS = DATA_W % SDRAM_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [31:0]       ADDR_STEP = 32'(BYTES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SEND = 1'b1;

  logic [0:0]        state_reg;
  logic [BEAT_W-1:0] beat_reg;
  logic [PAD_W-1:0]  shift_reg;
  logic [31:0]       addr_reg;
  logic              done_reg;

  logic [PAD_W-1:0]  data_ext;
  logic              beat_accept;
  logic              last_accept;

  // The vector is zero-extended to a whole number of beats so the padding of
  // a partial last beat falls out of the shift register as zeros.
  generate
    if (PAD_W > DATA_W) begin : g_pad
      assign data_ext = {{(PAD_W - DATA_W){1'b0}}, data_in};
    end else begin : g_nopad
      assign data_ext = data_in;
    end
  endgenerate

  assign beat_accept = (state_reg == S_SEND) && wr_ready;
  assign last_accept = beat_accept && (beat_reg == LAST_BEAT);

  // Burst sequencer: capture on start, advance one beat per handshake.
  // The current beat always sits in the low SDRAM_W bits of shift_reg; after
  // the final beat everything has been shifted out, so wr_data idles at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
      beat_reg  <= '0;
      shift_reg <= '0;
      addr_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= last_accept;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            state_reg <= S_SEND;
            beat_reg  <= '0;
            shift_reg <= data_ext;
            addr_reg  <= start_addr;
          end
        end
        S_SEND: begin
          // start is deliberately ignored here: no queueing of requests.
          if (beat_accept) begin
            shift_reg <= shift_reg >> SDRAM_W;
            if (beat_reg == LAST_BEAT) begin
              state_reg <= S_IDLE;
            end else begin
              beat_reg <= beat_reg + 1'b1;
              addr_reg <= addr_reg + ADDR_STEP;
            end
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // All outputs come straight from registers, so wr_valid has no
  // combinational path from wr_ready and the beat holds while stalled.
  assign wr_valid = (state_reg == S_SEND);
  assign busy     = (state_reg == S_SEND);
  assign done     = done_reg;
  assign wr_addr  = addr_reg;
  assign wr_data  = shift_reg[SDRAM_W-1:0];
  assign wr_last  = wr_valid && (beat_reg == LAST_BEAT);

`ifdef VEC_SDRAM_WR_BYTE_EN
  logic [BYTES-1:0] last_be;

  // Byte enables of the final beat: only bytes that hold vector data.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_last_be
      assign last_be[gi] = (REM_BITS == 0) || (gi < (REM_BITS / 8));
    end
  endgenerate

  assign wr_be = !wr_valid ? '0 : (wr_last ? last_be : '1);
`endif

endmodule

// File: tb/tb_vec_sdram_writer.sv
// Scoreboard bench for vec_sdram_writer: stimulus pushes expected beats into
// queues, negedge monitors pop and compare every accepted beat.
module tb_vec_sdram_writer;

  localparam int N1  = 176;
  localparam int N2  = 180;
  localparam int W   = 128;
  localparam int DW1 = N1 * 8;
  localparam int DW2 = N2 * 8;

  typedef struct packed {
    logic [31:0]  addr;
    logic [W-1:0] data;
    logic         last;
    logic [15:0]  be;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic           start, start2;
  logic [31:0]    start_addr, start_addr2;
  logic [DW1-1:0] data_in;
  logic [DW2-1:0] data_in2;
  logic           busy, done, wr_valid, wr_last, wr_ready;
  logic           busy2, done2, wr_valid2, wr_last2, wr_ready2;
  logic [31:0]    wr_addr, wr_addr2;
  logic [W-1:0]   wr_data, wr_data2;
`ifdef VEC_SDRAM_WR_BYTE_EN
  logic [15:0]    wr_be, wr_be2;
`endif

  vec_sdram_writer #(.N(N1), .SDRAM_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .data_in(data_in), .busy(busy), .done(done), .wr_valid(wr_valid),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_last(wr_last),
    .wr_ready(wr_ready)
`ifdef VEC_SDRAM_WR_BYTE_EN
    , .wr_be(wr_be)
`endif
  );

  vec_sdram_writer #(.N(N2), .SDRAM_W(W)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .start_addr(start_addr2),
    .data_in(data_in2), .busy(busy2), .done(done2), .wr_valid(wr_valid2),
    .wr_addr(wr_addr2), .wr_data(wr_data2), .wr_last(wr_last2),
    .wr_ready(wr_ready2)
`ifdef VEC_SDRAM_WR_BYTE_EN
    , .wr_be(wr_be2)
`endif
  );

  int checks = 0;
  int errors = 0;
  beat_t q1[$];
  beat_t q2[$];
  int hs_cnt = 0, done_cnt = 0, done2_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference beat: byte j of beat k is vector byte k*16+j, zero past the end.
  function automatic beat_t exp_beat(input logic [DW2-1:0] v, input int n,
                                     input logic [31:0] base, input int k);
    beat_t b;
    int beats;
    int idx;
    beats  = (n * 8 + W - 1) / W;
    b.addr = base + 32'(k * 16);
    b.data = '0;
    b.be   = '0;
    for (int j = 0; j < 16; j++) begin
      idx = k * 16 + j;
      if (idx < n) begin
        b.data[j*8 +: 8] = v[idx*8 +: 8];
        b.be[j] = 1'b1;
      end
    end
    b.last = (k == beats - 1);
    return b;
  endfunction

  task automatic start1(input logic [DW2-1:0] v, input logic [31:0] a, input bit push);
    start      = 1'b1;
    start_addr = a;
    data_in    = v[DW1-1:0];
    if (push) begin
      for (int k = 0; k < 11; k++) q1.push_back(exp_beat(v, N1, a, k));
      $display("start addr=%08h (expected burst queued)", a);
    end else begin
      $display("start addr=%08h (while busy, must be ignored)", a);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_hs(input string name, input int h0, input int target);
    int c = 0;
    while ((hs_cnt - h0) < target && c < 200) begin
      @(posedge clk);
      #1 c++;
    end
    chk(name, 128'(((hs_cnt - h0) >= target)), 128'(1));
  endtask

  task automatic wait_drain(input string name);
    int c = 0;
    while (q1.size() != 0 && c < 400) begin
      @(posedge clk);
      #1 c++;
    end
    chk(name, 128'(q1.size()), 128'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  // Monitor for the default-size instance: beat compare, stall stability,
  // done/busy exclusivity.
  logic  stall_prev = 1'b0;
  beat_t prev;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (done) done_cnt++;
      chk("done_busy_excl", 128'(done & busy), 128'(0));
      if (stall_prev) begin
        chk("stall_valid", 128'(wr_valid), 128'(1));
        chk("stall_addr", 128'(wr_addr), 128'(prev.addr));
        chk("stall_data", wr_data, prev.data);
        chk("stall_last", 128'(wr_last), 128'(prev.last));
      end
      if (wr_valid && wr_ready) begin
        if (q1.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got beat addr=%08h, required none", wr_addr);
        end else begin
          e = q1.pop_front();
          hs_cnt++;
          $display("beat addr=%08h data=%032h last=%0b", wr_addr, wr_data, wr_last);
          chk("beat_addr", 128'(wr_addr), 128'(e.addr));
          chk("beat_data", wr_data, e.data);
          chk("beat_last", 128'(wr_last), 128'(e.last));
`ifdef VEC_SDRAM_WR_BYTE_EN
          chk("beat_be", 128'(wr_be), 128'(e.be));
`endif
        end
      end
      stall_prev = wr_valid && !wr_ready;
      prev.addr  = wr_addr;
      prev.data  = wr_data;
      prev.last  = wr_last;
      prev.be    = '0;
    end
  end

  // Monitor for the N=180 instance (partial last beat).
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (done2) done2_cnt++;
      if (wr_valid2 && wr_ready2) begin
        if (q2.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat2: got beat addr=%08h, required none", wr_addr2);
        end else begin
          e = q2.pop_front();
          $display("beat2 addr=%08h data=%032h last=%0b", wr_addr2, wr_data2, wr_last2);
          chk("beat2_addr", 128'(wr_addr2), 128'(e.addr));
          chk("beat2_data", wr_data2, e.data);
          chk("beat2_last", 128'(wr_last2), 128'(e.last));
`ifdef VEC_SDRAM_WR_BYTE_EN
          chk("beat2_be", 128'(wr_be2), 128'(e.be));
`endif
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW2-1:0] va, vb, vc;
    int n, busy_cnt, d0, h0, stalls, c;

    for (int i = 0; i < N2; i++) begin
      va[i*8 +: 8] = 8'(i);
      vb[i*8 +: 8] = 8'(i * 3 + 7);
      vc[i*8 +: 8] = 8'(8'hA5 ^ 8'(i * 5));
    end

    rst_n = 1'b0; start = 1'b0; start2 = 1'b0;
    start_addr = '0; start_addr2 = '0; data_in = '0; data_in2 = '0;
    wr_ready = 1'b1; wr_ready2 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_valid", 128'(wr_valid), 128'(0));
    chk("rst_last", 128'(wr_last), 128'(0));
    chk("rst_addr", 128'(wr_addr), 128'(0));
    chk("rst_data", wr_data, 128'(0));
`ifdef VEC_SDRAM_WR_BYTE_EN
    chk("rst_be", 128'(wr_be), 128'(0));
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic burst: latency and busy width with wr_ready high.
    start1(va, 32'h1000, 1'b1);
    n = 0; busy_cnt = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) busy_cnt++;
      if (done) break;
    end
    chk("t1_done_latency", 128'(n), 128'(12));
    chk("t1_busy_cycles", 128'(busy_cnt), 128'(11));
    wait_drain("t1_drain");

    // Backpressure: 3-cycle stall on beat 4, then random ready.
    d0 = done_cnt; h0 = hs_cnt; stalls = 0; c = 0;
    start1(vb, 32'h3000, 1'b1);
    while (q1.size() != 0 && c < 400) begin
      @(posedge clk);
      #1 c++;
      if ((hs_cnt - h0) == 4 && stalls < 3) begin
        wr_ready = 1'b0;
        stalls++;
      end else if ((hs_cnt - h0) > 4) begin
        wr_ready = 1'($urandom_range(0, 1));
      end else begin
        wr_ready = 1'b1;
      end
    end
    wr_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t2_drain", 128'(q1.size()), 128'(0));
    chk("t2_beats", 128'(hs_cnt - h0), 128'(11));
    chk("t2_one_done", 128'(done_cnt - d0), 128'(1));

    // start re-pulsed during the burst must be ignored.
    d0 = done_cnt; h0 = hs_cnt;
    start1(va, 32'h4000, 1'b1);
    wait_hs("t4_reach_beat2", h0, 2);
    start1(vc, 32'h9000, 1'b0);
    wait_hs("t4_reach_beat7", h0, 7);
    start1(vb, 32'hA000, 1'b0);
    wait_drain("t4_drain");
    repeat (5) @(posedge clk);
    #1;
    chk("t4_beats", 128'(hs_cnt - h0), 128'(11));
    chk("t4_one_done", 128'(done_cnt - d0), 128'(1));

    // start in the done cycle: next burst begins immediately.
    start1(vc, 32'h5000, 1'b1);
    c = 0;
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (done) break;
    end
    chk("t5_done_seen", 128'(done), 128'(1));
    start1(va, 32'h2000, 1'b1);
    @(negedge clk);
    chk("t5_valid_next", 128'(wr_valid), 128'(1));
    chk("t5_addr_next", 128'(wr_addr), 128'(32'h2000));
    wait_drain("t5_drain");

    // Reset at beat 5 of a stalled burst.
    h0 = hs_cnt;
    start1(vb, 32'h6000, 1'b1);
    wait_hs("t6_reach_beat5", h0, 5);
    wr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_busy", 128'(busy), 128'(0));
    chk("t6_done", 128'(done), 128'(0));
    chk("t6_valid", 128'(wr_valid), 128'(0));
    chk("t6_last", 128'(wr_last), 128'(0));
    chk("t6_addr", 128'(wr_addr), 128'(0));
    chk("t6_data", wr_data, 128'(0));
`ifdef VEC_SDRAM_WR_BYTE_EN
    chk("t6_be", 128'(wr_be), 128'(0));
`endif
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    wr_ready = 1'b1;
    d0 = done_cnt;
    repeat (4) @(posedge clk);
    #1;
    chk("t6_no_done", 128'(done_cnt - d0), 128'(0));
    h0 = hs_cnt;
    start1(vc, 32'h7000, 1'b1);
    wait_drain("t6_restart_drain");
    chk("t6_restart_beats", 128'(hs_cnt - h0), 128'(11));

    // Address wrap modulo 2^32.
    start1(va, 32'hFFFF_FFC0, 1'b1);
    wait_drain("t7_wrap_drain");

    // N=180: 12 beats, partial last beat zero-padded.
    start2 = 1'b1;
    start_addr2 = 32'h8000;
    data_in2 = va;
    for (int k = 0; k < 12; k++) q2.push_back(exp_beat(va, N2, 32'h8000, k));
    $display("start2 addr=%08h (expected burst queued)", 32'h8000);
    @(posedge clk);
    #1 start2 = 1'b0;
    c = 0;
    while (q2.size() != 0 && c < 100) begin
      @(posedge clk);
      #1 c++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("t3_drain", 128'(q2.size()), 128'(0));
    chk("t3_one_done", 128'(done2_cnt), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
